data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit storage words (power of two, 4..4096).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the number of wait states per access (0..15).
REQ-003 Port CLK  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 Port RST  input  1  reset, asynchronous assert, active-low; state SHALL be held at reset values while RST=0.
REQ-005 Port MEMR  input  1  load request from the datapath.
REQ-006 Port MEMW  input  1  store request from the datapath.
REQ-007 Port ADDR  input  32  byte address.
REQ-008 Port WDATA  input  32  store data; the low byte/half SHALL be used for SB/SH.
REQ-009 Port FUNCT3  input  3  access size/sign code (RV32I load/store funct3).
REQ-010 Port MEM_DATA_R  output  32  load result, extended to 32 bits.
REQ-011 Port READY  output  1  response strobe, high for exactly one cycle per accepted request.
REQ-012 Port ERR  output  1  error flag, valid only while READY=1.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-014 In IDLE, if MEMR|MEMW=1 at a rising edge, the block SHALL capture ADDR, WDATA, FUNCT3, MEMR and MEMW, then go to WAIT with a counter loaded to WAIT_CYCLES (direct to RESP when WAIT_CYCLES=0).
REQ-015 WAIT SHALL decrement the counter each edge and go to RESP on the edge where the counter reaches 1.
REQ-016 RESP SHALL last one cycle and then return unconditionally to IDLE.
REQ-017 READY=1 SHALL appear WAIT_CYCLES+1 edges after acceptance, counting the accepting edge as edge 1.
REQ-018 The requester SHALL hold its request stable until READY; inputs after capture SHALL be ignored.
REQ-019 A request still asserted during RESP SHALL NOT be re-accepted; it SHALL be accepted at the first edge in IDLE.
REQ-020 Decode: FUNCT3 000=byte, 001=half, 010=word, 100=byte unsigned (load only), 101=half unsigned (load only); any other code SHALL set ERR.
REQ-021 A half access with ADDR[0]=1, or a word access with ADDR[1:0]!=0, SHALL set ERR.
REQ-022 ADDR >= 4*DEPTH_WORDS SHALL set ERR.
REQ-023 MEMR=1 and MEMW=1 together SHALL set ERR.
REQ-024 On ERR, no storage SHALL be modified and MEM_DATA_R SHALL be 0.
REQ-025 A valid store SHALL write only the addressed bytes, little-endian, at the edge that ends RESP; MEM_DATA_R SHALL be 0 for stores.
REQ-026 A valid load SHALL drive the selected bytes on MEM_DATA_R during RESP: sign-extended for 000/001, zero-extended for 100/101.
REQ-027 Outside RESP, MEM_DATA_R SHALL be 0, READY 0 and ERR 0.
REQ-028 A load immediately following a store to the same address SHALL return the newly stored data.

Reset
REQ-029 On RST=0, the FSM SHALL go to IDLE, the counter to 0, captured registers to 0, and READY/ERR/MEM_DATA_R to 0.
REQ-030 Storage contents SHALL NOT be reset.
REQ-031 Reset asserted during WAIT or RESP SHALL abort the access, and a pending store SHALL NOT be written.
REQ-032 The first request SHALL be accepted at the first rising edge after RST returns to 1.

Verification
REQ-033 SW 0xDEADBEEF to 0x10, then LW 0x10 (WAIT_CYCLES=2) -> READY on edge 3 after each acceptance, MEM_DATA_R=0xDEADBEEF, ERR=0.
REQ-034 SB 0x80 to 0x11, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
REQ-035 LW 0x12, SH 0x13 and FUNCT3=011 -> ERR=1, MEM_DATA_R=0, word at 0x10 unchanged.
REQ-036 LW at 0x400 (DEPTH_WORDS=256), and MEMR=MEMW=1 -> ERR=1, no write.
REQ-037 SW 0x12345678 to 0x20, with RST pulsed low during WAIT, then LW 0x20 -> no READY for the aborted access, old contents returned.
REQ-038 WAIT_CYCLES=0, back-to-back LW requests held high -> READY every second cycle, one pulse per request.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-organised data memory with a fixed wait-state handshake for RV32I loads and stores.
// Each accepted request produces exactly one READY pulse carrying ERR and the extended load data.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEMR,
  input  logic        MEMW,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  input  logic [2:0]  FUNCT3,
  output logic [31:0] MEM_DATA_R,
  output logic        READY,
  output logic        ERR
);

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        capture_s;
  logic [31:0] addr_r, wdata_r;
  logic [2:0]  funct3_r;
  logic        memr_r, memw_r;
  logic [31:0] rdata_r;
  logic        ready_r, err_r;

  logic [31:0] eff_addr_s;
  logic [2:0]  eff_funct3_s;
  logic        eff_memr_s, eff_memw_s;
  logic        err_s, resp_s, we_s;
  logic [31:0] word_s, load_s, lane_s;
  logic [3:0]  be_s;

  logic [31:0] mem_r [DEPTH_WORDS];

  function automatic logic access_err(input logic rd, input logic wr,
                                      input logic [2:0] f3, input logic [31:0] a);
    logic e;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = a[0];
      3'b010:  e = (a[1:0] != 2'b00);
      3'b100:  e = wr;
      3'b101:  e = wr | a[0];
      default: e = 1'b1;
    endcase
    return e | (rd & wr) | (a[31:AW+2] != {(30-AW){1'b0}});
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] off,
                                              input logic [2:0] f3);
    logic [31:0] sh;
    logic [31:0] res;
    sh = w >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b010:  res = sh;
      3'b100:  res = {24'h000000, sh[7:0]};
      3'b101:  res = {16'h0000, sh[15:0]};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the low byte/half across all lanes; byte enables pick the right one.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] l;
    case (f3[1:0])
      2'b00:   l = {4{d[7:0]}};
      2'b01:   l = {2{d[15:0]}};
      default: l = d;
    endcase
    return l;
  endfunction

  // In IDLE the response is formed from the live inputs so a zero-wait access can enter RESP directly.
  always_comb begin
    if (state_r == ST_IDLE) begin
      eff_addr_s   = ADDR;
      eff_funct3_s = FUNCT3;
      eff_memr_s   = MEMR;
      eff_memw_s   = MEMW;
    end else begin
      eff_addr_s   = addr_r;
      eff_funct3_s = funct3_r;
      eff_memr_s   = memr_r;
      eff_memw_s   = memw_r;
    end
  end

  assign word_s = mem_r[eff_addr_s[AW+1:2]];
  assign err_s  = access_err(eff_memr_s, eff_memw_s, eff_funct3_s, eff_addr_s);
  assign load_s = load_extend(word_s, eff_addr_s[1:0], eff_funct3_s);
  assign resp_s = (state_s == ST_RESP);

  // Next-state and wait counter.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (MEMR || MEMW) begin
          capture_s = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_s = ST_RESP;
            cnt_s   = 4'd0;
          end else begin
            state_s = ST_WAIT;
            cnt_s   = WAIT_LD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= 4'd1) begin
          state_s = ST_RESP;
          cnt_s   = 4'd0;
        end else begin
          cnt_s   = cnt_r - 4'd1;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State, counter and request capture registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      addr_r   <= 32'h0000_0000;
      wdata_r  <= 32'h0000_0000;
      funct3_r <= 3'b000;
      memr_r   <= 1'b0;
      memw_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (capture_s) begin
        addr_r   <= ADDR;
        wdata_r  <= WDATA;
        funct3_r <= FUNCT3;
        memr_r   <= MEMR;
        memw_r   <= MEMW;
      end
    end
  end

  // Response outputs are loaded on the edge entering RESP and cleared on the edge leaving it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      ready_r <= resp_s;
      err_r   <= resp_s & err_s;
      if (resp_s && !err_s && eff_memr_s && !eff_memw_s) begin
        rdata_r <= load_s;
      end else begin
        rdata_r <= 32'h0000_0000;
      end
    end
  end

  // Stores commit on the edge that ends RESP; reset forces IDLE, so an aborted store never lands.
  assign we_s   = (state_r == ST_RESP) && memw_r && !err_r;
  assign be_s   = byte_enable(funct3_r, addr_r[1:0]);
  assign lane_s = store_lanes(funct3_r, wdata_r);

  // Storage array, deliberately not reset.
  always_ff @(posedge CLK) begin
    if (we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem_r[addr_r[AW+1:2]][8*b +: 8] <= lane_s[8*b +: 8];
        end
      end
    end
  end

  assign MEM_DATA_R = rdata_r;
  assign READY      = ready_r;
  assign ERR        = err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised scoreboard bench for data_mem_responder with a byte-array reference model,
// plus a zero-wait instance for back-to-back handshake timing.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memr, memw;
  logic [31:0] addr, wdata, rdata;
  logic [2:0]  f3;
  logic        ready, err;

  logic        memr0, memw0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [2:0]  f3_0;
  logic        ready0, err0;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          rdy_edge;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [7:0]  model_mem [0:1023];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          free_edge = 0;
  bit          mon_on = 1'b0;

  localparam int WAITS = 2;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WAITS)) dut (
    .CLK(clk), .RST(rst), .MEMR(memr), .MEMW(memw), .ADDR(addr), .WDATA(wdata),
    .FUNCT3(f3), .MEM_DATA_R(rdata), .READY(ready), .ERR(err));

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .CLK(clk), .RST(rst), .MEMR(memr0), .MEMW(memw0), .ADDR(addr0), .WDATA(wdata0),
    .FUNCT3(f3_0), .MEM_DATA_R(rdata0), .READY(ready0), .ERR(err0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory as bytes, sizes and signs straight from the access rules.
  task automatic model_access(input logic rd, input logic wr, input logic [2:0] fn,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic e, output logic [31:0] d);
    int size;
    bit sgn;
    logic [31:0] v;
    e = 1'b0; d = 32'h0; size = 1; sgn = 1'b0;
    case (fn)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: begin size = 4; sgn = 1'b0; end
      3'd4: begin size = 1; sgn = 1'b0; if (wr) e = 1'b1; end
      3'd5: begin size = 2; sgn = 1'b0; if (wr) e = 1'b1; end
      default: e = 1'b1;
    endcase
    if (rd && wr) e = 1'b1;
    if (a % size != 0) e = 1'b1;
    if (a >= 32'd1024) e = 1'b1;
    if (!e) begin
      if (wr) begin
        for (int i = 0; i < size; i++) model_mem[a + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v = v | (32'(model_mem[a + i]) << (8 * i));
        if (sgn && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
        d = v;
      end
    end
  endtask

  // Issue one request, queue its expected response and hold until READY.
  task automatic do_req(input logic rd, input logic wr, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit use_k, input logic k_err, input logic [31:0] k_data);
    exp_t x;
    logic me;
    logic [31:0] md;
    int acc;
    bit got;
    memr = rd; memw = wr; f3 = fn; addr = a; wdata = wd;
    model_access(rd, wr, fn, a, wd, me, md);
    acc = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
    x.rdy_edge = acc + WAITS;
    free_edge  = x.rdy_edge + 2;
    x.err  = use_k ? k_err : me;
    x.data = use_k ? k_data : md;
    sb_q.push_back(x);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: no READY within 40 cycles, addr 0x%08h expected READY", a);
    end
  endtask

  task automatic idle(input int n);
    memr = 1'b0; memw = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every READY and checks idle outputs otherwise.
  always @(negedge clk) begin
    if (mon_on) begin
      if (ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got READY=1, expected 0 with nothing outstanding (edge %0d)", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          chk("ready_latency", 32'(cyc), 32'(mon_e.rdy_edge));
          chk("resp_err", {31'd0, err}, {31'd0, mon_e.err});
          chk("resp_data", rdata, mon_e.data);
        end
      end else begin
        chk("idle_outputs", {err, rdata[30:0]} | {31'd0, |rdata}, 32'h0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] old_w;
    int sel, pulses;
    logic [2:0] rf;
    logic [31:0] ra;
    memr = 1'b0; memw = 1'b0; addr = 32'h0; wdata = 32'h0; f3 = 3'd0;
    memr0 = 1'b0; memw0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; f3_0 = 3'd0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, ready}, 32'h0);
    chk("reset_err", {31'd0, err}, 32'h0);
    chk("reset_data", rdata, 32'h0);
    chk("reset_ready0", {31'd0, ready0}, 32'h0);
    rst = 1'b1;
    free_edge = cyc + 1;
    mon_on = 1'b1;

    // Preload the low 256 bytes so every later load reads defined data.
    for (int w = 0; w < 64; w++) do_req(1'b0, 1'b1, 3'd2, 32'(w * 4), $urandom, 1'b0, 1'b0, 32'h0);

    do_req(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    do_req(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
    do_req(1'b0, 1'b1, 3'd0, 32'h11, 32'h12345680, 1'b1, 1'b0, 32'h0);
    do_req(1'b1, 1'b0, 3'd0, 32'h11, 32'h0, 1'b1, 1'b0, 32'hFFFFFF80);
    do_req(1'b1, 1'b0, 3'd4, 32'h11, 32'h0, 1'b1, 1'b0, 32'h00000080);
    do_req(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEAD80EF);
    do_req(1'b1, 1'b0, 3'd1, 32'h12, 32'h0, 1'b1, 1'b0, 32'hFFFFDEAD);
    do_req(1'b1, 1'b0, 3'd5, 32'h12, 32'h0, 1'b1, 1'b0, 32'h0000DEAD);
    do_req(1'b1, 1'b0, 3'd2, 32'h12, 32'h0, 1'b1, 1'b1, 32'h0);
    do_req(1'b0, 1'b1, 3'd1, 32'h13, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
    do_req(1'b1, 1'b0, 3'd3, 32'h10, 32'h0, 1'b1, 1'b1, 32'h0);
    do_req(1'b0, 1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
    do_req(1'b1, 1'b0, 3'd2, 32'h400, 32'h0, 1'b1, 1'b1, 32'h0);
    do_req(1'b0, 1'b1, 3'd2, 32'h80000010, 32'h0, 1'b1, 1'b1, 32'h0);
    do_req(1'b1, 1'b1, 3'd2, 32'h10, 32'h00000000, 1'b1, 1'b1, 32'h0);
    do_req(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEAD80EF);
    do_req(1'b0, 1'b1, 3'd2, 32'h3FC, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0);
    do_req(1'b1, 1'b0, 3'd2, 32'h3FC, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D);

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      rf  = 3'($urandom_range(0, 7));
      ra  = (n % 2 == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 63) * 4);
      if ($urandom_range(0, 9) == 0) ra = 32'h400 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (rf[1:0] == 2'b10) ra[1:0] = 2'b00;
        else if (rf[1:0] == 2'b01) ra[0] = 1'b0;
        else ra = ra;
      end
      if (n % 7 == 3) idle($urandom_range(0, 3));
      do_req(sel == 0 || sel < 5, sel == 0 || sel >= 5, rf, ra, $urandom, 1'b0, 1'b0, 32'h0);
    end

    // Reset during WAIT must abort a store without writing it.
    idle(3);
    old_w = {model_mem[35], model_mem[34], model_mem[33], model_mem[32]};
    memw = 1'b1; f3 = 3'd2; addr = 32'h20; wdata = 32'h12345678;
    @(negedge clk);
    rst = 1'b0; memw = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    free_edge = cyc + 1;
    do_req(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, 1'b1, 1'b0, old_w);
    idle(3);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);

    // Zero-wait instance: a load held high is answered on every second cycle.
    memw0 = 1'b1; f3_0 = 3'd2; addr0 = 32'h40; wdata0 = 32'hA5A55A5A;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready0) break;
    end
    chk("b2b_store_ready", {31'd0, ready0}, 32'h1);
    chk("b2b_store_err", {31'd0, err0}, 32'h0);
    memw0 = 1'b0; memr0 = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("b2b_ready_pattern", {31'd0, ready0}, (k % 2 == 0) ? 32'h1 : 32'h0);
      if (ready0) begin
        pulses++;
        chk("b2b_load_data", rdata0, 32'hA5A55A5A);
        chk("b2b_load_err", {31'd0, err0}, 32'h0);
      end
    end
    memr0 = 1'b0;
    chk("b2b_pulse_count", 32'(pulses), 32'd10);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
